uart_rx_controller: RTL
=======================

Name: uart_rx_controller

Overview:
Receives 1 byte of serial UART data: start bit, 8 data bits (LSB first), optional parity bit, and stop bit. It is the receive-side counterpart of the UART transmit stage and consumes the serial line that the transmit stage drives. It runs on the system clock. Bit timing comes from a 16x-baud sample strobe supplied by the baud rate generator. Each received byte is presented as a parallel byte plus a one-cycle valid pulse.

Parameters:
OVERSAMPLE, 16, sample ticks per bit period; must be even and >= 4
SYNC_STAGES, 2, flip-flop stages in the i_Rx_Serial synchroniser; must be >= 2

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
i_Sample_Tick  input  1  one-clk strobe at OVERSAMPLE x baud rate; all bit timing advances only on cycles where this is high
i_Rx_Serial  input  1  asynchronous serial line; idles high
o_Rx_Byte  output  8  last correctly framed byte; held until the next good byte
o_Rx_Valid  output  1  one-clk pulse; o_Rx_Byte is new
o_Frame_Err  output  1  one-clk pulse; stop bit sampled low
o_Parity_Err  output  1  one-clk pulse; parity mismatch (tied 0 without the macro)
o_Rx_Busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values:
  - synchroniser flops = 1; FSM = IDLE; tick counter = 0; bit index = 0; shift register = 0x00
  - o_Rx_Byte = 0x00; o_Rx_Valid = 0; o_Frame_Err = 0; o_Parity_Err = 0; o_Rx_Busy = 0
  - Reset is honoured in any state. A byte in progress is discarded and no pulse is issued.
- Synchronised line (rx_s) = output of the SYNC_STAGES flop chain. All decisions use rx_s only.
- Tick counter: width clog2(OVERSAMPLE). It increments on i_Sample_Tick and is cleared on every state change.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
- IDLE:
  - Enter START on the first clk with rx_s = 0, regardless of i_Sample_Tick.
  - Counter cleared on entry to START.
- START:
  - On the tick where the counter reaches OVERSAMPLE/2-1, sample rx_s.
  - If rx_s = 1, this is a false start: return to IDLE with no output pulse.
  - If rx_s = 0, clear the counter and go to DATA. This places all later samples at mid-bit.
- DATA:
  - On each tick where the counter reaches OVERSAMPLE-1, sample rx_s into the shift register MSB and shift right (LSB first).
  - The counter wraps to 0 and the bit index increments.
  - After the 8th sample (bit index 7), go to PARITY if the macro is defined, otherwise to STOP. The bit index wraps to 0.
- STOP:
  - On the tick where the counter reaches OVERSAMPLE-1, sample rx_s.
  - If rx_s = 1: load o_Rx_Byte from the shift register, pulse o_Rx_Valid, go to IDLE.
  - If rx_s = 0: pulse o_Frame_Err, leave o_Rx_Byte unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s = 1, then go to IDLE. This prevents a break (line held low) from being read as repeated 0x00 frames.
- Pulse timing:
  - o_Rx_Valid, o_Frame_Err and o_Parity_Err are registered.
  - Each asserts on the clk edge after the stop-sample tick and lasts exactly 1 clk.
  - Valid and Frame_Err are never asserted together.
- Latency: o_Rx_Valid rises at (9.5 + P) x OVERSAMPLE ticks after the detected falling edge, plus synchroniser delay (SYNC_STAGES clks). P = 1 with parity, 0 without.
- Back-to-back frames: a start bit arriving immediately after the stop bit is accepted, because IDLE is re-entered at mid-stop-bit.
- i_Sample_Tick held low: the FSM freezes in its current state; no timeout.

Optional Feature:
Macro: UART_RX_PARITY_EN
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - The parity bit is sampled at mid-bit, OVERSAMPLE ticks after the last data sample.
  - Even parity: error if the XOR of the 8 data bits and the parity bit is 1.
  - On error, o_Parity_Err pulses in the same cycle the stop-bit outcome would pulse, and o_Rx_Valid is suppressed (o_Rx_Byte is not updated).
  - If the stop bit is also low, both o_Frame_Err and o_Parity_Err pulse.
- Not defined: no PARITY state; o_Parity_Err is tied to 0.

Test Plan:
- Send 0xA5 at 16x (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> o_Rx_Byte = 0xA5, o_Rx_Valid pulses 1 clk, o_Frame_Err = 0, o_Rx_Busy high during the frame then low.
- Send 0x00 then 0xFF back-to-back with no idle gap -> two o_Rx_Valid pulses with bytes 0x00 then 0xFF, no errors.
- Drive the line low for 4 sample ticks, then high -> returns to IDLE, no pulse on any output, o_Rx_Byte unchanged.
- Send 0x3C with stop bit 0, then hold the line low for 2 bit times, then high -> single o_Frame_Err pulse, o_Rx_Byte keeps its previous value, o_Rx_Busy stays high until the line returns high, then a following 0x55 is received correctly.
- Assert reset_n low during data bit 4 of 0x81 -> all outputs return to their reset values immediately, no valid pulse; the next frame 0x81 is received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> o_Rx_Valid, 0x07; then send 0x07 with parity bit 0 -> o_Parity_Err pulse, no o_Rx_Valid, o_Rx_Byte remains 0x07.

Source files
------------

// File: rtl/uart_rx_controller.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_controller
// Function : Oversampled UART receiver (8 data bits, LSB first, 1 stop bit).
//            Define UART_RX_PARITY_EN to add an even-parity bit before stop.
// Revision : 1.0
// ============================================================================
module uart_rx_controller #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_Sample_Tick,
    input  logic       i_Rx_Serial,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Valid,
    output logic       o_Frame_Err,
    output logic       o_Parity_Err,
    output logic       o_Rx_Busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] c_FULL_LAST = CNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
        , S_PARITY  = 3'd5
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             byte_q, byte_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   perr_q, perr_d;
    logic                   par_bad;
    logic                   full_tick;

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign full_tick = i_Sample_Tick && (cnt_q == c_FULL_LAST);

`ifdef UART_RX_PARITY_EN
    logic par_err_q, par_err_d;
    assign par_bad = par_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) par_err_q <= 1'b0;
        else          par_err_q <= par_err_d;
    end
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        if (i_Sample_Tick) cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                // A start bit still low at mid-bit anchors every later sample.
                if (i_Sample_Tick && (cnt_q == c_HALF_LAST))
                    state_d = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (full_tick) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = '0;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (full_tick) begin
                    par_err_d = ^{shift_q, rx_s};
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (full_tick) begin
                    if (rx_s) begin
                        if (par_bad) begin
                            perr_d = 1'b1;
                        end else begin
                            byte_d  = shift_q;
                            valid_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        perr_d  = par_bad;
                        state_d = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // Hold off until a break ends so it is not seen as 0x00 frames.
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i_Rx_Serial};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    assign o_Rx_Byte    = byte_q;
    assign o_Rx_Valid   = valid_q;
    assign o_Frame_Err  = ferr_q;
    assign o_Parity_Err = perr_q;
    assign o_Rx_Busy    = (state_q != S_IDLE);

endmodule
`default_nettype wire
